// File: rtl/dm_abstractcmd_ctrl.sv
// Abstract-command sequencer: latches the command, runs the go/going/done handshake with the
// halted hart, and maintains abstractcs.busy and the sticky cmderr field.
module dm_abstractcmd_ctrl #(
    parameter int unsigned CMDERR_W = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dmactive_i,
    input  logic                cmd_wr_i,
    input  logic [31:0]         cmd_wdata_i,
    input  logic                autoexec_i,
    input  logic                data_access_i,
    input  logic [CMDERR_W-1:0] cmderr_clr_i,
    input  logic                unsupported_command_i,
    input  logic                hart_halted_i,
    input  logic                hart_going_i,
    input  logic                hart_done_i,
    input  logic                hart_exception_i,
    output logic [31:0]         cmd_o,
    output logic                go_o,
    output logic                busy_o,
    output logic [CMDERR_W-1:0] cmderr_o
);

    typedef enum logic [1:0] {StIdle, StCheck, StGo, StExec} state_e;

    localparam logic [CMDERR_W-1:0] ErrNone       = CMDERR_W'(0);
    localparam logic [CMDERR_W-1:0] ErrBusy       = CMDERR_W'(1);
    localparam logic [CMDERR_W-1:0] ErrNotSup     = CMDERR_W'(2);
    localparam logic [CMDERR_W-1:0] ErrException  = CMDERR_W'(3);
    localparam logic [CMDERR_W-1:0] ErrHaltResume = CMDERR_W'(4);

    state_e                state_q, state_d;
    logic [31:0]           cmd_q, cmd_d;
    logic                  go_q, go_d;
    logic [CMDERR_W-1:0]   cmderr_q, cmderr_d;
    logic [CMDERR_W-1:0]   fsm_err;
    logic [CMDERR_W-1:0]   err_evt;
    logic                  busy_viol;
    logic                  start_ok;

    assign start_ok  = (cmderr_q == ErrNone);
    assign busy_viol = (state_q != StIdle) & (cmd_wr_i | autoexec_i | data_access_i);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fsm_err carries the error raised by the transition taken
    always_comb begin
        state_d = state_q;
        fsm_err = ErrNone;
        unique case (state_q)
            StIdle: begin
                if ((cmd_wr_i || autoexec_i) && start_ok) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (unsupported_command_i) begin
                    fsm_err = ErrNotSup;
                    state_d = StIdle;
                end else if (!hart_halted_i) begin
                    fsm_err = ErrHaltResume;
                    state_d = StIdle;
                end else begin
                    state_d = StGo;
                end
            end
            StGo: begin
                if (!hart_halted_i) begin
                    fsm_err = ErrHaltResume;
                    state_d = StIdle;
                end else if (hart_going_i) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (hart_exception_i) begin
                    fsm_err = ErrException;
                    state_d = StIdle;
                end else if (!hart_halted_i) begin
                    fsm_err = ErrHaltResume;
                    state_d = StIdle;
                end else if (hart_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!dmactive_i) begin
            state_d = StIdle;
            fsm_err = ErrNone;
        end
    end

    // Output / datapath next values
    always_comb begin
        cmd_d    = cmd_q;
        cmderr_d = cmderr_q;
        err_evt  = ErrNone;
        if (state_q == StIdle && cmd_wr_i && start_ok) begin
            cmd_d = cmd_wdata_i;
        end
        if (fsm_err != ErrNone) begin
            err_evt = fsm_err;
        end else if (busy_viol) begin
            err_evt = ErrBusy;
        end
        // Any error event masks the W1C clear; only the first error code is kept
        if (err_evt != ErrNone) begin
            cmderr_d = start_ok ? err_evt : cmderr_q;
        end else begin
            cmderr_d = cmderr_q & ~cmderr_clr_i;
        end
        go_d = (state_d == StGo);
        if (!dmactive_i) begin
            cmd_d    = '0;
            cmderr_d = ErrNone;
            go_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q    <= '0;
            go_q     <= 1'b0;
            cmderr_q <= ErrNone;
        end else begin
            cmd_q    <= cmd_d;
            go_q     <= go_d;
            cmderr_q <= cmderr_d;
        end
    end

    assign cmd_o    = cmd_q;
    assign go_o     = go_q;
    assign busy_o   = (state_q != StIdle);
    assign cmderr_o = cmderr_q;

endmodule

// File: tb/tb_dm_abstractcmd_ctrl.sv
// Self-checking bench: directed test-plan scenarios followed by random pulses, all outputs
// compared every cycle against a transaction-level model of the command sequencer.
module tb_dm_abstractcmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmactive, cmd_wr, autoexec, data_access;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmderr_clr;
    logic        unsup_force, unsupported;
    logic        halted, going, done, exc;
    logic [31:0] cmd_o;
    logic        go_o, busy_o;
    logic [2:0]  cmderr_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Generator model: only command type 0 (access register) is supported
    assign unsupported = unsup_force | (cmd_o[31:24] != 8'h00);

    dm_abstractcmd_ctrl #(.CMDERR_W(3)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .dmactive_i            (dmactive),
        .cmd_wr_i              (cmd_wr),
        .cmd_wdata_i           (cmd_wdata),
        .autoexec_i            (autoexec),
        .data_access_i         (data_access),
        .cmderr_clr_i          (cmderr_clr),
        .unsupported_command_i (unsupported),
        .hart_halted_i         (halted),
        .hart_going_i          (going),
        .hart_done_i           (done),
        .hart_exception_i      (exc),
        .cmd_o                 (cmd_o),
        .go_o                  (go_o),
        .busy_o                (busy_o),
        .cmderr_o              (cmderr_o)
    );

    // Reference model: phase is a plain string naming where the command is
    string       m_phase;
    logic [31:0] m_cmd;
    logic [2:0]  m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = "idle";
        m_cmd   = 32'h0;
        m_err   = 3'd0;
    endtask

    task automatic model_step();
        int    code;
        string nxt;
        bit    m_unsup;
        if (!dmactive) begin
            model_reset();
            return;
        end
        code    = 0;
        nxt     = m_phase;
        m_unsup = unsup_force || (m_cmd[31:24] != 8'h00);
        if (m_phase == "idle") begin
            if (m_err == 0 && cmd_wr) begin
                m_cmd = cmd_wdata;
                nxt   = "check";
            end else if (m_err == 0 && autoexec) begin
                nxt = "check";
            end
        end else if (m_phase == "check") begin
            if (m_unsup)      begin code = 2; nxt = "idle"; end
            else if (!halted) begin code = 4; nxt = "idle"; end
            else nxt = "go";
        end else if (m_phase == "go") begin
            if (!halted)     begin code = 4; nxt = "idle"; end
            else if (going)  nxt = "exec";
        end else begin
            if (exc)          begin code = 3; nxt = "idle"; end
            else if (!halted) begin code = 4; nxt = "idle"; end
            else if (done)    nxt = "idle";
        end
        if (code == 0 && m_phase != "idle" && (cmd_wr || autoexec || data_access)) code = 1;
        if (code != 0) begin
            if (m_err == 0) m_err = 3'(code);
        end else begin
            m_err = m_err & ~cmderr_clr;
        end
        m_phase = nxt;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".cmd"},    cmd_o,    m_cmd);
        check_eq({tag, ".go"},     32'(go_o),   32'(m_phase == "go"));
        check_eq({tag, ".busy"},   32'(busy_o), 32'(m_phase != "idle"));
        check_eq({tag, ".cmderr"}, 32'(cmderr_o), 32'(m_err));
    endtask

    task automatic clear_pulses();
        cmd_wr = 0; autoexec = 0; data_access = 0; cmderr_clr = 3'b000;
        going = 0; done = 0; exc = 0;
    endtask

    // One clock: inputs already driven; update model, sample 1 time unit after the edge
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        clear_pulses();
    endtask

    initial begin
        rst = 1; dmactive = 1; halted = 1; unsup_force = 0; cmd_wdata = 32'h0;
        clear_pulses();
        model_reset();
        #3;
        check_all("reset");
        #9 rst = 0;

        // Normal command
        cmd_wr = 1; cmd_wdata = 32'h0023_1000;
        cycle("norm_wr");
        check_eq("norm_busy_rise", 32'(busy_o), 32'd1);
        cycle("norm_check");
        check_eq("norm_go_rise", 32'(go_o), 32'd1);
        going = 1; cycle("norm_going");
        cycle("norm_exec");
        done = 1; cycle("norm_done");
        check_eq("norm_cmd", cmd_o, 32'h0023_1000);
        check_eq("norm_idle", 32'({busy_o, cmderr_o}), 32'd0);

        // Unsupported, ignored rewrite, clear
        unsup_force = 1; cmd_wr = 1; cmd_wdata = 32'h0022_1001;
        cycle("unsup_wr");
        cycle("unsup_check");
        check_eq("unsup_err", 32'(cmderr_o), 32'd2);
        cmd_wr = 1; cmd_wdata = 32'h0022_1002;
        cycle("unsup_rewr");
        check_eq("unsup_keep", cmd_o, 32'h0022_1001);
        unsup_force = 0; cmderr_clr = 3'b111;
        cycle("unsup_clr");

        // Busy violations in GO and EXEC
        cmd_wr = 1; cmd_wdata = 32'h0023_1002;
        cycle("bv_wr");
        cycle("bv_check");
        cmd_wr = 1; cmd_wdata = 32'h0023_1fff;
        cycle("bv_wr_go");
        check_eq("bv_keep", cmd_o, 32'h0023_1002);
        going = 1; cycle("bv_going");
        data_access = 1; cycle("bv_data");
        done = 1; cycle("bv_done");
        check_eq("bv_err", 32'(cmderr_o), 32'd1);
        cmderr_clr = 3'b001; cycle("bv_clr");

        // Exception + done + clear on the same edge
        cmd_wr = 1; cmd_wdata = 32'h0023_1003;
        cycle("exc_wr"); cycle("exc_check");
        going = 1; cycle("exc_going");
        exc = 1; done = 1; cmderr_clr = 3'b111; cycle("exc_evt");
        check_eq("exc_err", 32'(cmderr_o), 32'd3);
        cmderr_clr = 3'b111; cycle("exc_clr");

        // Not halted at CHECK, then halt lost during EXEC
        halted = 0; cmd_wr = 1; cmd_wdata = 32'h0023_1004;
        cycle("nh_wr"); cycle("nh_check");
        check_eq("nh_err", 32'(cmderr_o), 32'd4);
        halted = 1; cmderr_clr = 3'b100; cycle("nh_clr");
        cmd_wr = 1; cmd_wdata = 32'h0023_1005;
        cycle("nh2_wr"); cycle("nh2_check");
        going = 1; cycle("nh2_going");
        halted = 0; cycle("nh2_drop");
        check_eq("nh2_state", 32'({go_o, busy_o, cmderr_o}), 32'd4);
        halted = 1; cmderr_clr = 3'b111; cycle("nh2_clr");

        // Autoexec re-runs latched command; dmactive clear mid-command
        autoexec = 1; cycle("ae_start");
        check_eq("ae_cmd", cmd_o, 32'h0023_1005);
        cycle("ae_check");
        dmactive = 0; cycle("dm_clr");
        check_eq("dm_zero", 32'({go_o, busy_o, cmderr_o}) | cmd_o, 32'd0);
        dmactive = 1; cycle("dm_back");

        // Asynchronous reset in EXEC
        cmd_wr = 1; cmd_wdata = 32'h0023_1006;
        cycle("ar_wr"); cycle("ar_check");
        going = 1; cycle("ar_going");
        #2 rst = 1;
        #1 model_reset();
        check_all("ar_async");
        #3 rst = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 2) halted = ~halted;
            dmactive    = ($urandom_range(0, 199) != 0);
            unsup_force = ($urandom_range(0, 29) == 0);
            cmd_wr      = ($urandom_range(0, 9) == 0);
            cmd_wdata   = ($urandom_range(0, 4) == 0) ? $urandom : {8'h00, 24'($urandom)};
            autoexec    = ($urandom_range(0, 19) == 0);
            data_access = ($urandom_range(0, 19) == 0);
            cmderr_clr  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            going       = ($urandom_range(0, 4) == 0);
            done        = ($urandom_range(0, 4) == 0);
            exc         = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
